// File: rtl/cpu_mult_seq_cell.sv
// Sequential multiply cell: accumulates PART_W x PART_W partial products of the operand
// magnitudes, one per cycle, then applies the sign and returns the low (MUL) or high
// (MULX*) DATA_W bits behind a valid/ready handshake.
// DATA_W must be a multiple of PART_W.
module cpu_mult_seq_cell #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned PART_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [1:0]        in_op_i,
    input  logic [DATA_W-1:0] in_src1_i,
    input  logic [DATA_W-1:0] in_src2_i,
    input  logic              abort_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_result_o,
    output logic              busy_o
);

    localparam int unsigned N    = DATA_W / PART_W;
    localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned AccW = 2 * DATA_W;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(N - 1);

    localparam logic [1:0] OpMul    = 2'b00;
    localparam logic [1:0] OpMulxss = 2'b11;

    typedef enum logic [1:0] {StIdle, StMac, StFix, StDone} state_e;

    state_e            state_q;
    logic [1:0]        op_q;
    logic [DATA_W-1:0] a_mag_q, b_mag_q;
    logic              neg_q;
    logic [AccW-1:0]   acc_q;
    logic [IdxW-1:0]   i_q, j_q;
    logic              out_valid_q;
    logic [DATA_W-1:0] out_result_q;

    logic              a_neg, b_neg, neg_in;
    logic [DATA_W-1:0] a_mag, b_mag;
    logic [PART_W-1:0] part_a, part_b;
    logic [2*PART_W-1:0] prod;
    int unsigned       shamt;
    logic [AccW-1:0]   addend;
    logic [AccW-1:0]   acc_fix;
    logic [IdxW-1:0]   last_j;
    logic              last_pair;

    // Operand magnitudes and result sign, evaluated at the accept edge.
    always_comb begin
        a_neg  = in_op_i[1] & in_src1_i[DATA_W-1];
        b_neg  = (in_op_i == OpMulxss) & in_src2_i[DATA_W-1];
        // The most negative value negates to itself, which is its correct magnitude.
        a_mag  = a_neg ? (~in_src1_i + 1'b1) : in_src1_i;
        b_mag  = b_neg ? (~in_src2_i + 1'b1) : in_src2_i;
        // The low half is sign-agnostic, so MUL never negates.
        neg_in = (a_neg ^ b_neg) & (in_op_i != OpMul);
    end

    // Current partial product, its shifted addend and the pair-sequencing decision.
    always_comb begin
        part_a    = a_mag_q[32'(i_q) * PART_W +: PART_W];
        part_b    = b_mag_q[32'(j_q) * PART_W +: PART_W];
        prod      = {{PART_W{1'b0}}, part_a} * {{PART_W{1'b0}}, part_b};
        shamt     = PART_W * (32'(i_q) + 32'(j_q));
        addend    = AccW'(prod) << shamt;
        // MUL stops each row at i+j = N-1; products above that only touch the high half.
        last_j    = (op_q == OpMul) ? (LastIdx - i_q) : LastIdx;
        last_pair = (i_q == LastIdx) && (j_q == last_j);
        acc_fix   = neg_q ? (~acc_q + 1'b1) : acc_q;
    end

    // Control FSM with datapath registers and registered outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            op_q         <= 2'b00;
            a_mag_q      <= '0;
            b_mag_q      <= '0;
            neg_q        <= 1'b0;
            acc_q        <= '0;
            i_q          <= '0;
            j_q          <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
        end else if (abort_i) begin
            // Abort wins over accept and over the result handshake.
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid_i) begin
                        op_q    <= in_op_i;
                        a_mag_q <= a_mag;
                        b_mag_q <= b_mag;
                        neg_q   <= neg_in;
                        acc_q   <= '0;
                        i_q     <= '0;
                        j_q     <= '0;
                        state_q <= StMac;
                    end
                end
                StMac: begin
                    acc_q <= acc_q + addend;
                    if (last_pair) begin
                        state_q <= StFix;
                    end else if (j_q == last_j) begin
                        i_q <= i_q + 1'b1;
                        j_q <= '0;
                    end else begin
                        j_q <= j_q + 1'b1;
                    end
                end
                StFix: begin
                    out_result_q <= (op_q == OpMul) ? acc_fix[DATA_W-1:0]
                                                    : acc_fix[AccW-1:DATA_W];
                    out_valid_q  <= 1'b1;
                    state_q      <= StDone;
                end
                StDone: begin
                    if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Ready must drop asynchronously with reset and be up right after it releases.
    assign in_ready_o   = (state_q == StIdle) & ~rst_i;
    assign busy_o       = (state_q == StMac) | (state_q == StFix);
    assign out_valid_o  = out_valid_q;
    assign out_result_o = out_result_q;

endmodule

// File: tb/tb_cpu_mult_seq_cell.sv
// Bench for cpu_mult_seq_cell: three instances (32/16, 64/16, 16/16) sharing the operand
// buses; one is exercised at a time, with a scoreboard queue of expected results.
module tb_cpu_mult_seq_cell;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  op = 2'b00;
    logic [63:0] src1 = '0, src2 = '0;
    logic [2:0]  in_valid = '0;
    logic        abort = 1'b0;
    logic        out_ready = 1'b0;
    wire  [2:0]  in_ready, out_valid, busy;
    wire  [31:0] res32;
    wire  [63:0] res64;
    wire  [15:0] res16;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    typedef struct {
        logic [63:0] res;
        int          lat;
    } exp_t;

    vec_t vecs[10];
    exp_t sb_q[$];

    always #5 clk = ~clk;

    cpu_mult_seq_cell #(.DATA_W(32), .PART_W(16)) u_dut32 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid[0]), .in_ready_o(in_ready[0]),
        .in_op_i(op), .in_src1_i(src1[31:0]), .in_src2_i(src2[31:0]), .abort_i(abort),
        .out_valid_o(out_valid[0]), .out_ready_i(out_ready), .out_result_o(res32),
        .busy_o(busy[0])
    );

    cpu_mult_seq_cell #(.DATA_W(64), .PART_W(16)) u_dut64 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid[1]), .in_ready_o(in_ready[1]),
        .in_op_i(op), .in_src1_i(src1), .in_src2_i(src2), .abort_i(abort),
        .out_valid_o(out_valid[1]), .out_ready_i(out_ready), .out_result_o(res64),
        .busy_o(busy[1])
    );

    cpu_mult_seq_cell #(.DATA_W(16), .PART_W(16)) u_dut16 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid[2]), .in_ready_o(in_ready[2]),
        .in_op_i(op), .in_src1_i(src1[15:0]), .in_src2_i(src2[15:0]), .abort_i(abort),
        .out_valid_o(out_valid[2]), .out_ready_i(out_ready), .out_result_o(res16),
        .busy_o(busy[2])
    );

    function automatic logic [63:0] get_result(int sel);
        if (sel == 0) return {32'd0, res32};
        if (sel == 1) return res64;
        return {48'd0, res16};
    endfunction

    // Reference: sign-extend to 128 bits and multiply modulo 2^128.
    function automatic logic [63:0] ref_result(logic [1:0] o, logic [63:0] a, logic [63:0] b,
                                               int w);
        logic [127:0] mask, ea, eb, p;
        mask = (128'd1 << w) - 128'd1;
        ea   = {64'd0, a} & mask;
        eb   = {64'd0, b} & mask;
        if (o[1] && a[w-1]) ea = ea | ~mask;
        if (o == 2'b11 && b[w-1]) eb = eb | ~mask;
        p = ea * eb;
        if (o == 2'b00) return p[63:0] & mask[63:0];
        return (p >> w) & {64'd0, mask[63:0]};
    endfunction

    function automatic int ref_lat(logic [1:0] o, int n);
        return (o == 2'b00) ? (n * (n + 1) / 2 + 1) : (n * n + 1);
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one request, score latency and result, optionally backpressure, then handshake.
    task automatic do_op(int sel, logic [1:0] o, logic [63:0] a, logic [63:0] b,
                         logic [63:0] exp, int lat, int hold);
        int          cycles;
        logic        ready_low;
        logic        stable;
        logic [63:0] r0;
        exp_t        e;
        check("ready_before_accept", {63'd0, in_ready[sel]}, 64'd1);
        op  = o;
        src1 = a;
        src2 = b;
        in_valid[sel] = 1'b1;
        sb_q.push_back('{res: exp, lat: lat});
        @(posedge clk); #1;
        in_valid[sel] = 1'b0;
        // Operands must be ignored once accepted.
        src1 = ~a;
        src2 = ~b;
        op   = ~o;
        cycles    = 0;
        ready_low = 1'b1;
        while (!out_valid[sel] && cycles < 200) begin
            if (in_ready[sel]) ready_low = 1'b0;
            @(posedge clk); #1;
            cycles++;
        end
        e = sb_q.pop_front();
        if (!out_valid[sel]) begin
            errors++;
            checks++;
            $display("FAIL out_valid_timeout: got 0 expected 1 within 200 cycles");
            return;
        end
        check("result", get_result(sel), e.res);
        check("latency", 64'(cycles), 64'(e.lat));
        check("in_ready_low_while_busy", {63'd0, ready_low}, 64'd1);
        if (hold > 0) begin
            r0     = get_result(sel);
            stable = 1'b1;
            repeat (hold) begin
                @(posedge clk); #1;
                if (!out_valid[sel] || get_result(sel) !== r0 || in_ready[sel]) stable = 1'b0;
            end
            check("backpressure_hold", {63'd0, stable}, 64'd1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("handshake_valid_drop", {63'd0, out_valid[sel]}, 64'd0);
        check("handshake_ready_rise", {63'd0, in_ready[sel]}, 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          seen;
        logic [1:0]  ro;
        logic [63:0] ra, rb;

        vecs[0] = '{2'b01, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFE, 5};
        vecs[1] = '{2'b11, 64'h80000000, 64'h80000000, 64'h40000000, 5};
        vecs[2] = '{2'b10, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFF, 5};
        vecs[3] = '{2'b11, 64'hFFFFFFFE, 64'h00000003, 64'hFFFFFFFF, 5};
        vecs[4] = '{2'b00, 64'h00012345, 64'h00010000, 64'h23450000, 4};
        vecs[5] = '{2'b00, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'h00000001, 4};
        vecs[6] = '{2'b01, 64'h00000003, 64'h00000005, 64'h00000000, 5};
        vecs[7] = '{2'b11, 64'h7FFFFFFF, 64'h7FFFFFFF, 64'h3FFFFFFF, 5};
        vecs[8] = '{2'b00, 64'hFFFFFFFE, 64'h00000003, 64'hFFFFFFFA, 4};
        vecs[9] = '{2'b10, 64'h80000000, 64'h00000002, 64'hFFFFFFFF, 5};

        // Reset state.
        #2;
        check("reset_in_ready", {61'd0, in_ready}, 64'd0);
        check("reset_out_valid", {61'd0, out_valid}, 64'd0);
        check("reset_busy", {61'd0, busy}, 64'd0);
        @(negedge clk); rst = 1'b0;
        #1;

        foreach (vecs[k]) do_op(0, vecs[k].op, vecs[k].a, vecs[k].b, vecs[k].exp, vecs[k].lat, 0);

        // Backpressure: 2^16 * 2^16 has high word 1.
        do_op(0, 2'b01, 64'h00010000, 64'h00010000, 64'h00000001, 5, 10);

        // Abort in IDLE blocks a same-cycle accept.
        abort = 1'b1; in_valid[0] = 1'b1; op = 2'b01; src1 = 64'd7; src2 = 64'd9;
        @(posedge clk); #1;
        abort = 1'b0; in_valid[0] = 1'b0;
        check("idle_abort_blocks_accept", {63'd0, busy[0]}, 64'd0);

        // Abort at MAC cycle 2 together with a new request.
        op = 2'b01; src1 = 64'hFFFFFFFF; src2 = 64'hFFFFFFFF; in_valid[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        @(posedge clk); #1;
        abort = 1'b1; in_valid[0] = 1'b1; src1 = 64'd11; src2 = 64'd13;
        @(posedge clk); #1;
        abort = 1'b0; in_valid[0] = 1'b0;
        check("mac_abort_idle", {62'd0, busy[0], in_ready[0]}, 64'd1);
        seen = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (out_valid[0] || busy[0]) seen++;
        end
        check("mac_abort_no_result", 64'(seen), 64'd0);
        do_op(0, 2'b01, 64'd3, 64'd5, 64'd0, 5, 0);

        // Abort while the result is held in DONE.
        op = 2'b01; src1 = 64'h00010000; src2 = 64'h00030000; in_valid[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        seen = 0;
        while (!out_valid[0] && seen < 50) begin
            @(posedge clk); #1;
            seen++;
        end
        check("done_result", get_result(0), 64'd3);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("done_abort_valid", {62'd0, out_valid[0], in_ready[0]}, 64'd1);

        // Asynchronous reset mid-MAC; previous result was nonzero.
        op = 2'b01; src1 = 64'h12345678; src2 = 64'h9ABCDEF0; in_valid[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("async_rst_outputs", {28'd0, busy[0], out_valid[0], in_ready[0], res32}, 64'd0);
        @(negedge clk); rst = 1'b0;
        #1;
        check("post_rst_ready", {63'd0, in_ready[0]}, 64'd1);
        do_op(0, 2'b00, 64'h00012345, 64'h00010000, 64'h23450000, 4, 0);

        // 64/16 (N=4) against the reference model.
        for (int k = 0; k < 16; k++) begin
            ro = 2'($urandom_range(0, 3));
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            if (k == 0) begin ra = 64'h8000000000000000; rb = 64'h8000000000000000; ro = 2'b11; end
            if (k == 1) begin ra = '1; rb = '1; ro = 2'b10; end
            do_op(1, ro, ra, rb, ref_result(ro, ra, rb, 64), ref_lat(ro, 4), 0);
        end

        // 16/16 (N=1) against the reference model.
        for (int k = 0; k < 12; k++) begin
            ro = 2'(k % 4);
            ra = {48'd0, 16'($urandom)};
            rb = {48'd0, 16'($urandom)};
            if (k < 4) begin ra = 64'h8000; rb = 64'hFFFF; end
            do_op(2, ro, ra, rb, ref_result(ro, ra, rb, 16), ref_lat(ro, 1), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_mult_seq_cell.md
# cpu_mult_seq_cell

Parametrised sequential multiply cell for the Nios II CPU datapath. It produces the DATA_W-bit result of the MUL, MULXUU, MULXSU and MULXSS operations by accumulating PART_W×PART_W partial products through a single hardware multiplier, one product per cycle. It sits behind the A-stage multiply request path and uses a valid/ready handshake on both the operand side and the result side. It replaces the fixed two-product, low-half-only cell.

## Interface
- DATA_W, 32, operand and result width; must be a multiple of PART_W.
- PART_W, 16, width of each multiplier-chunk operand; N = DATA_W/PART_W, N ≥ 1.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand request.
- in_ready  out  1  high only in IDLE.
- in_op  in  2  operation select: 00 MUL, 01 MULXUU, 10 MULXSU, 11 MULXSS.
- in_src1  in  DATA_W  operand A.
- in_src2  in  DATA_W  operand B.
- abort  in  1  synchronous cancel of any in-flight or held operation.
- out_valid  out  1  result available; held until accepted.
- out_ready  in  1  consumer accepts the result.
- out_result  out  DATA_W  result; stable while out_valid is high.
- busy  out  1  high in MAC or FIX.

## Operation
- States: IDLE, MAC, FIX, DONE. Reset forces IDLE. While in reset, in_ready is 0, out_valid is 0, busy is 0, out_result is 0, and the accumulator and counters are cleared.
- Accept (in_valid & in_ready & ~abort): capture in_op and the operand magnitudes. For the signed operands (src1 under 10/11, src2 under 11), the magnitude is |x| as a DATA_W-bit unsigned value; the most negative value maps to 2^(DATA_W-1). Capture neg = sign(src1_signed) XOR sign(src2_signed). Clear the accumulator (2·DATA_W bits). Go to MAC.
- MAC: on each cycle, add a_i·b_j << (PART_W·(i+j)) to the accumulator. a_i and b_j are PART_W chunks of the magnitudes, and the index pairs run in order i outer, j inner, from 0.
  - MUL (00) skips every pair with i+j ≥ N, so P = N(N+1)/2 products.
  - All other ops use all pairs, so P = N² products.
  - After the last product, go to FIX.
- FIX: if neg = 1, take the two's complement of the accumulator (2·DATA_W bits).
  - out_result is the low DATA_W bits for MUL and the high DATA_W bits otherwise.
  - Set out_valid = 1 and go to DONE.
  - For MUL, neg is forced to 0; the low half is sign-agnostic.
- DONE: hold out_result and out_valid. When out_ready is high, clear out_valid and go to IDLE.
- abort, in any state: go to IDLE next edge and clear out_valid. abort has priority over accept and over out_ready. Abort is a no-op in IDLE, except that it blocks an accept in the same cycle.
- Arithmetic: all accumulation is unsigned modulo 2^(2·DATA_W). No overflow flag.

## Timing
- Accept at edge 0. MAC products occur at edges 1..P. FIX occurs at edge P+1. out_valid is high from edge P+1 onward.
- Latency from accept edge to out_valid is P+1 cycles.
  - DATA_W=32, PART_W=16: MUL takes 4 cycles; MULX* takes 5 cycles.
  - N=1: MUL and MULX* both take 2 cycles.
- The minimum gap between results on back-to-back requests is P+3 cycles: the DONE handshake cycle plus one IDLE cycle before the next accept.
- Inputs are sampled only at the accept edge. Changes to in_src*/in_op afterwards are ignored.
- out_result changes only at the FIX edge, or on reset/abort. Reset/abort clears out_valid only; out_result is not required to change on abort.
- Reset asserted mid-MAC or mid-DONE: all outputs reach their reset values immediately (asynchronous). The first accept is possible on the first edge after reset deasserts.

## Test plan
- Default params, MULXUU with 0xFFFFFFFF × 0xFFFFFFFF -> out_result 0xFFFFFFFE; out_valid 5 cycles after accept; in_ready 0 throughout.
- MULXSS with 0x80000000 × 0x80000000 -> 0x40000000. MULXSU with 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFF. MULXSS with 0xFFFFFFFE × 0x00000003 -> 0xFFFFFFFF.
- MUL with 0x00012345 × 0x00010000 -> 0x23450000, out_valid 4 cycles after accept. MUL with 0xFFFFFFFF × 0xFFFFFFFF -> 0x00000001.
- Result backpressure: hold out_ready=0 for 10 cycles -> out_valid and out_result stable and in_ready stays 0. Raise out_ready -> out_valid drops next edge and in_ready rises.
- abort at MAC cycle 2 together with in_valid=1 -> IDLE next edge with no result and no accept in that cycle; a following MULXUU 3 × 5 -> 0x00000000.
- Reset pulse mid-MAC -> all outputs 0 without waiting for a clock. Then run with DATA_W=64, PART_W=16 on random ops against a reference model (N=4: MUL 11 cycles, MULX* 17 cycles) and with N=1 (DATA_W=PART_W=16) -> 2 cycles for MUL and MULX*.
